// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one 32-bit ALU between the EXE stage (port 0)
// and the auxiliary address/compare unit (port 1). It grants one request
// per cycle round-robin, drives the shared ALU, and holds one registered
// result/overflow tagged with the owning port. A flush empties the buffer.
//
// Opcode bits (one-hot, src2 is the shifted value, src1[4:0] the amount):
//   0 add | 1 sub | 2 slt | 3 sltu | 4 and | 5 or | 6 xor | 7 nor
//   8 sll | 9 srl | 10 sra | 11 lui (src2[15:0] << 16)
module alu_share_arb #(
   parameter int W   = 32,
   parameter int OPW = 12
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flush,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_src1,
   input  logic [W-1:0]   req0_src2,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_src1,
   input  logic [W-1:0]   req1_src2,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp_result,
   output logic           rsp_overflow,
   output logic           busy
);

   logic           full;
   logic           owner;
   logic           last;
   logic [W-1:0]   result;
   logic           ovf;

   logic           drain;
   logic           cap;
   logic           grant_any;
   logic           grant_sel;
   logic           accept;

   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [W-1:0]   alu_result;
   logic           alu_overflow;
   logic [W-1:0]   sum;
   logic [W-1:0]   diff;
   logic [4:0]     shamt;

   // Round-robin grant, buffer capacity and request handshakes.
   always_comb begin
      drain      = full & ((~owner & rsp0_ready) | (owner & rsp1_ready));
      cap        = resetn & ~flush & (~full | drain);
      grant_any  = req0_valid | req1_valid;
      grant_sel  = (req0_valid & req1_valid) ? ~last : req1_valid;
      req0_ready = cap & grant_any & ~grant_sel;
      req1_ready = cap & grant_any & grant_sel;
      accept     = cap & grant_any;
   end

   // Shared ALU fed from whichever port holds the grant; unselected
   // opcode terms mask to zero, so an all-zero opcode yields 0.
   always_comb begin
      alu_op       = grant_sel ? req1_op   : req0_op;
      alu_a        = grant_sel ? req1_src1 : req0_src1;
      alu_b        = grant_sel ? req1_src2 : req0_src2;
      sum          = alu_a + alu_b;
      diff         = alu_a - alu_b;
      shamt        = alu_a[4:0];
      alu_result   = ({W{alu_op[0]}}  & sum)
                   | ({W{alu_op[1]}}  & diff)
                   | ({W{alu_op[2]}}  & {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))})
                   | ({W{alu_op[3]}}  & {{(W-1){1'b0}}, (alu_a < alu_b)})
                   | ({W{alu_op[4]}}  & (alu_a & alu_b))
                   | ({W{alu_op[5]}}  & (alu_a | alu_b))
                   | ({W{alu_op[6]}}  & (alu_a ^ alu_b))
                   | ({W{alu_op[7]}}  & ~(alu_a | alu_b))
                   | ({W{alu_op[8]}}  & (alu_b << shamt))
                   | ({W{alu_op[9]}}  & (alu_b >> shamt))
                   | ({W{alu_op[10]}} & W'($signed(alu_b) >>> shamt))
                   | ({W{alu_op[11]}} & (alu_b << 16));
      alu_overflow = (alu_op[0] & (alu_a[W-1] == alu_b[W-1]) & (sum[W-1]  != alu_a[W-1]))
                   | (alu_op[1] & (alu_a[W-1] != alu_b[W-1]) & (diff[W-1] != alu_a[W-1]));
   end

   // Response buffer: flush beats everything, accept overwrites (even while
   // draining), a plain drain empties it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full   <= 1'b0;
         owner  <= 1'b0;
         last   <= 1'b1;
         result <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (accept) begin
         full   <= 1'b1;
         owner  <= grant_sel;
         last   <= grant_sel;
         result <= alu_result;
         ovf    <= alu_overflow;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

   // Response side is a direct view of the buffer.
   always_comb begin
      rsp0_valid   = full & ~owner;
      rsp1_valid   = full & owner;
      rsp_result   = result;
      rsp_overflow = ovf;
      busy         = full;
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset values, tie-break, overflow,
// backpressure with drain+accept, flush, streaming fairness, async reset.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [11:0] req0_op = '0, req1_op = '0;
   logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [31:0] rsp_result;
   logic        rsp_overflow;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int g0 = 0, g1 = 0;

   alu_share_arb #(.W(32), .OPW(12)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src1(req0_src1), .req0_src2(req0_src2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src1(req1_src1), .req1_src2(req1_src2),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held, request pending: nothing may be accepted.
      req0_valid = 1'b1;
      #12;
      chk("rst_busy",   busy, 0);
      chk("rst_r0v",    rsp0_valid, 0);
      chk("rst_r1v",    rsp1_valid, 0);
      chk("rst_res",    rsp_result, 0);
      chk("rst_ovf",    rsp_overflow, 0);
      chk("rst_rdy0",   req0_ready, 0);
      req0_valid = 1'b0;
      #8 resetn = 1'b1;
      cyc();

      // Tie after reset: port 0 sub 5-7, port 1 sltu 1<2.
      req0_valid = 1; req0_op = 12'h002; req0_src1 = 5; req0_src2 = 7;
      req1_valid = 1; req1_op = 12'h008; req1_src1 = 1; req1_src2 = 2;
      #1;
      chk("tie_rdy0", req0_ready, 1);
      chk("tie_rdy1", req1_ready, 0);
      cyc();
      req0_valid = 0;
      chk("tie_r0v",  rsp0_valid, 1);
      chk("tie_res0", rsp_result, 32'hFFFF_FFFE);
      chk("tie_ovf0", rsp_overflow, 0);
      #1;
      chk("tie_rdy1b", req1_ready, 1);
      cyc();
      req1_valid = 0;
      chk("tie_r1v",  rsp1_valid, 1);
      chk("tie_r0v2", rsp0_valid, 0);
      chk("tie_res1", rsp_result, 32'h0000_0001);
      cyc();
      chk("tie_idle", busy, 0);

      // Single add on port 0 with signed overflow.
      req0_valid = 1; req0_op = 12'h001; req0_src1 = 32'h7FFF_FFFF; req0_src2 = 1;
      #1;
      chk("add_rdy0", req0_ready, 1);
      cyc();
      req0_valid = 0;
      chk("add_r0v", rsp0_valid, 1);
      chk("add_r1v", rsp1_valid, 0);
      chk("add_res", rsp_result, 32'h8000_0000);
      chk("add_ovf", rsp_overflow, 1);

      // Sub overflow: 0x80000000 - 1.
      req0_valid = 1; req0_op = 12'h002; req0_src1 = 32'h8000_0000; req0_src2 = 1;
      cyc();
      req0_valid = 0;
      chk("sub_res", rsp_result, 32'h7FFF_FFFF);
      chk("sub_ovf", rsp_overflow, 1);

      // Zero opcode gives zero result and no overflow.
      req0_valid = 1; req0_op = 12'h000; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'hFFFF_FFFF;
      cyc();
      req0_valid = 0;
      chk("op0_res", rsp_result, 0);
      chk("op0_ovf", rsp_overflow, 0);
      chk("op0_r0v", rsp0_valid, 1);
      cyc();

      // Backpressure: lui on port 0 held while port 1 waits.
      req0_valid = 1; req0_op = 12'h800; req0_src1 = 0; req0_src2 = 32'h1234;
      cyc();
      req0_valid = 0; rsp0_ready = 0;
      req1_valid = 1; req1_op = 12'h001; req1_src1 = 3; req1_src2 = 4;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_res",  rsp_result, 32'h1234_0000);
         chk("bp_r0v",  rsp0_valid, 1);
         chk("bp_rdy1", req1_ready, 0);
         cyc();
      end
      rsp0_ready = 1;
      #1;
      chk("bp_drain_acc", req1_ready, 1);
      cyc();
      req1_valid = 0;
      chk("bp_r1v",  rsp1_valid, 1);
      chk("bp_r0v2", rsp0_valid, 0);
      chk("bp_res2", rsp_result, 32'h0000_0007);
      chk("bp_busy", busy, 1);

      // Flush while port 1 result is stalled and port 0 is requesting.
      rsp1_ready = 0; flush = 1;
      req0_valid = 1; req0_op = 12'h001; req0_src1 = 1; req0_src2 = 1;
      #1;
      chk("fl_rdy0", req0_ready, 0);
      cyc();
      flush = 0;
      chk("fl_busy", busy, 0);
      chk("fl_r1v",  rsp1_valid, 0);
      chk("fl_r0v",  rsp0_valid, 0);
      #1;
      chk("fl_rdy0b", req0_ready, 1);
      cyc();
      req0_valid = 0; rsp1_ready = 1;
      chk("fl_r0v2", rsp0_valid, 1);
      chk("fl_res",  rsp_result, 32'h0000_0002);

      // Streaming: last grant was port 0, so port 1 leads.
      req0_valid = 1; req0_op = 12'h400; req0_src1 = 4; req0_src2 = 32'h8000_0000;
      req1_valid = 1; req1_op = 12'h400; req1_src1 = 4; req1_src2 = 32'h8000_0000;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("st_rdy1", req1_ready, (i % 2 == 0) ? 1 : 0);
         chk("st_rdy0", req0_ready, (i % 2 == 0) ? 0 : 1);
         if (req0_ready) g0++;
         if (req1_ready) g1++;
         cyc();
         chk("st_res", rsp_result, 32'hF800_0000);
         chk("st_r1v", rsp1_valid, (i % 2 == 0) ? 1 : 0);
      end
      req0_valid = 0; req1_valid = 0;
      chk("st_g0", g0, 4);
      chk("st_g1", g1, 4);

      // Async reset while full: outputs clear before any clock edge.
      rsp0_ready = 0;
      #1;
      chk("ar_pre_busy", busy, 1);
      #1 resetn = 0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_r0v",  rsp0_valid, 0);
      chk("ar_r1v",  rsp1_valid, 0);
      chk("ar_res",  rsp_result, 0);
      #3 resetn = 1; rsp0_ready = 1;
      req0_valid = 1; req0_op = 12'h001; req0_src1 = 2; req0_src2 = 3;
      req1_valid = 1; req1_op = 12'h001; req1_src1 = 4; req1_src2 = 5;
      #1;
      chk("ar_tie0", req0_ready, 1);
      chk("ar_tie1", req1_ready, 0);
      cyc();
      req0_valid = 0; req1_valid = 0;
      chk("ar_res2", rsp_result, 32'h0000_0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one 32-bit ALU instance between two requesters: the EXE stage (port 0) and the auxiliary address/compare unit (port 1). Requests are valid/ready handshakes carrying the 12-bit one-hot ALU opcode and two operands. The block grants one request per cycle with round-robin priority, drives the shared ALU, and registers the result and overflow into a single response buffer tagged with the owning port. A pipeline flush input discards buffered work.

## Interface
- `W`, default 32: operand/result width; only 32 is supported.
- `OPW`, default 12: opcode width, one-hot ALU op encoding (bit0 add … bit11 lui).
- `clk` input 1: clock, rising edge.
- `resetn` input 1: one clock; reset is asynchronous and active-low.
- `flush` input 1: discard the response buffer; block acceptance this cycle.
- `req0_valid`, `req1_valid` input 1: request present.
- `req0_ready`, `req1_ready` output 1: request accepted at this edge when valid&ready.
- `req0_op`, `req1_op` input OPW: one-hot ALU opcode.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2` input W: operands.
- `rsp0_valid`, `rsp1_valid` output 1: buffered result belongs to this port.
- `rsp0_ready`, `rsp1_ready` input 1: consumer takes the result.
- `rsp_result` output W: buffered ALU result, shared by both ports.
- `rsp_overflow` output 1: buffered signed add/sub overflow flag.
- `busy` output 1: response buffer full.

## Operation
- State: `full`, `owner` (0/1), `last` (last granted port), `result`, `ovf`.
- Drain: `drain = full & ((owner==0 & rsp0_ready) | (owner==1 & rsp1_ready))`.
- Accept capacity: `cap = ~flush & (~full | drain)`.
- Grant: if only one reqN_valid, grant N; if both valid, grant the port ≠ `last`; if neither, no grant.
- `reqN_ready = cap & grant==N`. Ready is 0 for a non-granted port even when valid. Ready never depends on the requester's own valid, except through the grant choice.
- ALU inputs are muxed combinationally from the granted port. Opcode zero gives result 0 and overflow 0. Multi-hot opcodes are illegal, and results for them are unspecified.
- On accept: `full←1`, `owner←N`, `result←alu_result`, `ovf←alu_overflow`, `last←N`.
- On drain without accept: `full←0`. Drain and accept in the same cycle: the buffer is overwritten with the new result, and `full` stays 1.
- Overflow is reported only for ops add (bit0) and sub (bit1). Signed rules: add overflows when the operand signs are equal and the result sign differs. Sub overflows when the operand signs differ and the result sign differs from src1.
- `rspN_valid = full & owner==N`.
- `flush`: `full←0` at the edge. No accept that cycle. `last` is unchanged. Flush overrides a simultaneous drain.
- `busy = full`.

## Timing
- Reset (async assert, sync release) values: `full=0`, `owner=0`, `last=1` (port 0 wins the first tie), `result=0`, `ovf=0`. Hence `rsp*_valid=0`, `rsp_result=0`, `rsp_overflow=0`, `busy=0`. `reqN_ready` is 0 while `resetn=0`.
- Latency: a request accepted at edge t gives rspN_valid=1 with data in the cycle after t.
- Throughput: 1 request/cycle when the owner consumer holds rsp ready high. With both ports continuously valid, grants alternate 0,1,0,1.
- Backpressure: while the owner's rsp ready=0, the buffer, owner, result and overflow hold stable, and both req readys stay 0.
- Reset asserted mid-operation clears the buffer immediately, without waiting for a clock edge. A result pending at reset is lost.
- Request inputs are sampled only at the accepting edge. Requesters hold op/src stable while valid&~ready.

## Test plan
- Single add, port 0: op=0x001, src1=0x7FFFFFFF, src2=0x00000001, rsp0_ready=1 → next cycle rsp0_valid=1, rsp_result=0x80000000, rsp_overflow=1; rsp1_valid=0.
- Tie after reset: both valid. Port 0 sub 5-7 (op=0x002), port 1 sltu 1<2 (op=0x008), consumers ready → cycle 1: rsp0, result 0xFFFFFFFE, ovf 0. Cycle 2: rsp1, result 0x00000001. req1_ready=0 in the first grant cycle.
- Backpressure: port 0 lui src2=0x1234 (op=0x800), rsp0_ready=0 for 3 cycles with port 1 valid → result holds 0x12340000, req1_ready=0 throughout. When rsp0_ready rises, port 1 is accepted in the same cycle (drain+accept).
- Flush: buffer full with port 1 result, rsp1_ready=0, and flush=1 while port 0 is valid → next cycle busy=0, rsp1_valid=0, and port 0 not accepted. Port 0 is accepted the cycle after.
- Streaming fairness: both ports valid for 8 cycles with sra 0x80000000>>4 (op=0x400, src1=4) → grants alternate, 4 per port, each result 0xF8000000.
- Async reset mid-op: assert resetn=0 between edges while full → rsp*_valid, busy and rsp_result drop to 0 immediately. After release, the first tie goes to port 0.
